vdma_frame_buf_ctrl: RTL

//  Per-channel multi-frame buffer address controller for the multiports VDMA.

---
 rtl/vdma_frame_buf_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/vdma_frame_buf_ctrl.sv
// vdma_frame_buf_ctrl: per-channel multi-frame slot rotation for the multiports VDMA.
// The writer and reader each own one of NFRAME slots per channel. The reader always
// moves to the newest fully committed frame. The writer skips the slot the reader holds.
// Optional build macro VDMA_FRAME_STAT_EN adds 16-bit saturating per-channel statistics.
// Without the macro, rd_repeat_cnt and wr_frame_cnt are tied to zero.
`timescale 1ns / 1ps

module vdma_frame_buf_ctrl #(
  parameter int unsigned NCH        = 8,
  parameter int unsigned ASIZE      = 29,
  parameter int unsigned NFRAME     = 3,
  parameter int unsigned FRAME_STEP = 2211840
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic [NCH-1:0]   ch_enable,
  input  logic [ASIZE-1:0] cfg_base       [NCH-1:0],
  input  logic [NCH-1:0]   wr_frame_start,
  input  logic [NCH-1:0]   wr_frame_done,
  input  logic [NCH-1:0]   rd_frame_start,
  output logic [ASIZE-1:0] wr_baseaddr    [NCH-1:0],
  output logic [ASIZE-1:0] rd_baseaddr    [NCH-1:0],
  output logic [NCH-1:0]   rd_repeat,
  output logic [15:0]      rd_repeat_cnt  [NCH-1:0],
  output logic [15:0]      wr_frame_cnt   [NCH-1:0]
);

  localparam int unsigned       IW      = $clog2(NFRAME);
  localparam logic [IW-1:0]     LastIdx = IW'(NFRAME - 1);
  localparam logic [ASIZE+IW-1:0] Step  = (ASIZE + IW)'(FRAME_STEP);

  // Slot index successor, modulo NFRAME.
  function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + IW'(1);
  endfunction

  // base + idx * FRAME_STEP. The sum wraps modulo 2^ASIZE.
  function automatic logic [ASIZE-1:0] slot_addr(input logic [ASIZE-1:0] base,
                                                 input logic [IW-1:0]    idx);
    logic [ASIZE+IW-1:0] prod;
    prod = (ASIZE + IW)'(idx) * Step;
    return base + prod[ASIZE-1:0];
  endfunction

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [IW-1:0]    last_done_q, last_done_d;
    logic             done_vld_q, done_vld_d;
    logic             rep_q, rep_d;
    logic             done_eff;
    logic [IW-1:0]    done_idx;
    logic [IW-1:0]    wr_cand;
    logic [ASIZE-1:0] wr_addr_q, rd_addr_q;

    // Next state: resolve the done bypass, let the reader pick, then advance the writer.
    // The writer advances around the reader's new slot.
    always_comb begin
      done_eff    = wr_frame_done[c] | done_vld_q;
      // A done in this same cycle is the newest frame, so it beats the stored one.
      done_idx    = wr_frame_done[c] ? wr_idx_q : last_done_q;
      rd_idx_d    = rd_idx_q;
      wr_idx_d    = wr_idx_q;
      last_done_d = last_done_q;
      done_vld_d  = done_vld_q;
      rep_d       = 1'b0;
      wr_cand     = idx_inc(wr_idx_q);
      if (!ch_enable[c]) begin
        rd_idx_d    = LastIdx;
        wr_idx_d    = '0;
        last_done_d = '0;
        done_vld_d  = 1'b0;
      end else begin
        if (rd_frame_start[c]) begin
          if (done_eff && (done_idx != rd_idx_q)) begin
            rd_idx_d = done_idx;
          end else begin
            rep_d = 1'b1;
          end
        end
        if (wr_frame_start[c]) begin
          // With NFRAME=2 the double step can land back on the old slot.
          // That overwrites the slot in place and is allowed.
          if (wr_cand == rd_idx_d) begin
            wr_cand = idx_inc(wr_cand);
          end
          wr_idx_d = wr_cand;
        end
        if (wr_frame_done[c]) begin
          last_done_d = wr_idx_q;
          done_vld_d  = 1'b1;
        end
      end
    end

    // Slot state and registered addresses, computed from next-state indices.
    // This gives one cycle of latency.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
        wr_idx_q    <= '0;
        rd_idx_q    <= LastIdx;
        last_done_q <= '0;
        done_vld_q  <= 1'b0;
        rep_q       <= 1'b0;
        wr_addr_q   <= '0;
        rd_addr_q   <= '0;
      end else begin
        wr_idx_q    <= wr_idx_d;
        rd_idx_q    <= rd_idx_d;
        last_done_q <= last_done_d;
        done_vld_q  <= done_vld_d;
        rep_q       <= rep_d;
        wr_addr_q   <= slot_addr(cfg_base[c], wr_idx_d);
        rd_addr_q   <= slot_addr(cfg_base[c], rd_idx_d);
      end
    end

    assign wr_baseaddr[c] = wr_addr_q;
    assign rd_baseaddr[c] = rd_addr_q;
    assign rd_repeat[c]   = rep_q;

`ifdef VDMA_FRAME_STAT_EN
    logic [15:0] rep_cnt_q, wfr_cnt_q;

    // Saturating statistics. The repeat count steps together with the rd_repeat pulse.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
        rep_cnt_q <= '0;
        wfr_cnt_q <= '0;
      end else if (!ch_enable[c]) begin
        rep_cnt_q <= '0;
        wfr_cnt_q <= '0;
      end else begin
        if (rep_d && (rep_cnt_q != 16'hFFFF)) begin
          rep_cnt_q <= rep_cnt_q + 16'd1;
        end
        if (wr_frame_done[c] && (wfr_cnt_q != 16'hFFFF)) begin
          wfr_cnt_q <= wfr_cnt_q + 16'd1;
        end
      end
    end

    assign rd_repeat_cnt[c] = rep_cnt_q;
    assign wr_frame_cnt[c]  = wfr_cnt_q;
`else
    assign rd_repeat_cnt[c] = '0;
    assign wr_frame_cnt[c]  = '0;
`endif
  end

endmodule
